// File: rtl/alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_req_scheduler
// Description : Two-requester round-robin front end for the ALU datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_req_scheduler #(
    parameter int DWIDTH  = 8,
    parameter int CWIDTH  = 4,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DWIDTH-1:0] req0_opa,
    input  logic [DWIDTH-1:0] req0_opb,
    input  logic [CWIDTH-1:0] req0_cmd,
    input  logic              req0_mode,
    input  logic              req0_cin,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DWIDTH-1:0] req1_opa,
    input  logic [DWIDTH-1:0] req1_opb,
    input  logic [CWIDTH-1:0] req1_cmd,
    input  logic              req1_mode,
    input  logic              req1_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DWIDTH:0]   rsp_res,
    output logic              alu_ce,
    output logic [DWIDTH-1:0] alu_opa,
    output logic [DWIDTH-1:0] alu_opb,
    output logic [CWIDTH-1:0] alu_cmd,
    output logic              alu_mode,
    output logic              alu_cin,
    output logic [1:0]        alu_inp_valid,
    input  logic [DWIDTH:0]   alu_res,
    output logic              busy
);
    localparam int c_LAT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int c_CNT_W   = $clog2(c_LAT_MAX + 1);

    localparam logic [CWIDTH-1:0] c_A_INC_A   = CWIDTH'(4);
    localparam logic [CWIDTH-1:0] c_A_DEC_A   = CWIDTH'(5);
    localparam logic [CWIDTH-1:0] c_A_INC_B   = CWIDTH'(6);
    localparam logic [CWIDTH-1:0] c_A_DEC_B   = CWIDTH'(7);
    localparam logic [CWIDTH-1:0] c_A_ADD_MUL = CWIDTH'(9);
    localparam logic [CWIDTH-1:0] c_A_SH_MUL  = CWIDTH'(10);
    localparam logic [CWIDTH-1:0] c_L_NOT_A   = CWIDTH'(6);
    localparam logic [CWIDTH-1:0] c_L_NOT_B   = CWIDTH'(7);
    localparam logic [CWIDTH-1:0] c_L_SHR1_A  = CWIDTH'(8);
    localparam logic [CWIDTH-1:0] c_L_SHL1_A  = CWIDTH'(9);
    localparam logic [CWIDTH-1:0] c_L_SHR1_B  = CWIDTH'(10);
    localparam logic [CWIDTH-1:0] c_L_SHL1_B  = CWIDTH'(11);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_rr_prio;
    logic                r_op_id;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [DWIDTH:0]     r_rsp_res;
    logic                r_alu_ce;
    logic [DWIDTH-1:0]   r_alu_opa;
    logic [DWIDTH-1:0]   r_alu_opb;
    logic [CWIDTH-1:0]   r_alu_cmd;
    logic                r_alu_mode;
    logic                r_alu_cin;
    logic [1:0]          r_alu_iv;

    logic                w_idle;
    logic                w_grant0;
    logic                w_grant1;
    logic [DWIDTH-1:0]   w_opa;
    logic [DWIDTH-1:0]   w_opb;
    logic [CWIDTH-1:0]   w_cmd;
    logic                w_mode;
    logic                w_cin;
    logic [1:0]          w_iv;
    logic [c_CNT_W-1:0]  w_lat;

    function automatic logic [1:0] f_inp_valid(input logic [CWIDTH-1:0] cmd, input logic mode);
        logic [1:0] v;
        v = 2'b11;
        if (mode) begin
            if (cmd == c_A_INC_A || cmd == c_A_DEC_A)
                v = 2'b01;
            else if (cmd == c_A_INC_B || cmd == c_A_DEC_B)
                v = 2'b10;
        end else begin
            if (cmd == c_L_NOT_A || cmd == c_L_SHR1_A || cmd == c_L_SHL1_A)
                v = 2'b01;
            else if (cmd == c_L_NOT_B || cmd == c_L_SHR1_B || cmd == c_L_SHL1_B)
                v = 2'b10;
        end
        return v;
    endfunction

    // r_rr_prio names the requester that wins when both are valid.
    assign w_idle   = rst && (r_state == S_IDLE);
    assign w_grant0 = w_idle && req0_valid && (!req1_valid || !r_rr_prio);
    assign w_grant1 = w_idle && req1_valid && (!req0_valid ||  r_rr_prio);

    assign w_opa  = w_grant1 ? req1_opa  : req0_opa;
    assign w_opb  = w_grant1 ? req1_opb  : req0_opb;
    assign w_cmd  = w_grant1 ? req1_cmd  : req0_cmd;
    assign w_mode = w_grant1 ? req1_mode : req0_mode;
    assign w_cin  = w_grant1 ? req1_cin  : req0_cin;
    assign w_iv   = f_inp_valid(w_cmd, w_mode);
    assign w_lat  = (w_mode && (w_cmd == c_A_ADD_MUL || w_cmd == c_A_SH_MUL))
                  ? c_CNT_W'(MUL_LAT) : c_CNT_W'(ALU_LAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_rr_prio   <= 1'b0;
            r_op_id     <= 1'b0;
            r_cnt       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_res   <= '0;
            r_alu_ce    <= 1'b0;
            r_alu_opa   <= '0;
            r_alu_opb   <= '0;
            r_alu_cmd   <= '0;
            r_alu_mode  <= 1'b0;
            r_alu_cin   <= 1'b0;
            r_alu_iv    <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        // Operands go straight to the ALU registers so they are live during ISSUE.
                        r_alu_opa  <= w_opa;
                        r_alu_opb  <= w_opb;
                        r_alu_cmd  <= w_cmd;
                        r_alu_mode <= w_mode;
                        r_alu_cin  <= w_cin;
                        r_alu_iv   <= w_iv;
                        r_alu_ce   <= 1'b1;
                        r_cnt      <= w_lat;
                        r_op_id    <= w_grant1;
                        r_rr_prio  <= ~w_grant1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == c_CNT_W'(1)) begin
                        r_rsp_res   <= alu_res;
                        r_rsp_id    <= r_op_id;
                        r_rsp_valid <= 1'b1;
                        r_alu_ce    <= 1'b0;
                        r_alu_iv    <= 2'b00;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready    = w_grant0;
    assign req1_ready    = w_grant1;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_id        = r_rsp_id;
    assign rsp_res       = r_rsp_res;
    assign alu_ce        = r_alu_ce;
    assign alu_opa       = r_alu_opa;
    assign alu_opb       = r_alu_opb;
    assign alu_cmd       = r_alu_cmd;
    assign alu_mode      = r_alu_mode;
    assign alu_cin       = r_alu_cin;
    assign alu_inp_valid = r_alu_iv;
    assign busy          = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_req_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_req_scheduler
// Description : Self-checking bench for alu_req_scheduler with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_req_scheduler;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_opa = '0, req0_opb = '0, req1_opa = '0, req1_opb = '0;
    logic [3:0] req0_cmd = '0, req1_cmd = '0;
    logic       req0_mode = 1'b0, req0_cin = 1'b0, req1_mode = 1'b0, req1_cin = 1'b0;
    logic       rsp_valid, rsp_id;
    logic       rsp_ready = 1'b0;
    logic [8:0] rsp_res;
    logic       alu_ce, alu_mode, alu_cin, busy;
    logic [7:0] alu_opa, alu_opb;
    logic [3:0] alu_cmd;
    logic [1:0] alu_inp_valid;
    logic [8:0] alu_res = '0;

    int total = 0;
    int bad   = 0;
    int m_prio = 0;
    logic [7:0] f_opa [2];
    logic [7:0] f_opb [2];
    logic [3:0] f_cmd [2];
    logic       f_mode[2];
    logic       f_cin [2];

    typedef struct {
        int         id;
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [1:0] iv;
        int         lat;
        logic [8:0] res;
        int         bp;
    } vec_t;

    alu_req_scheduler dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb),
        .req0_cmd(req0_cmd), .req0_mode(req0_mode), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb),
        .req1_cmd(req1_cmd), .req1_mode(req1_mode), .req1_cin(req1_cin),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
        .alu_ce(alu_ce), .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
        .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_inp_valid(alu_inp_valid),
        .alu_res(alu_res), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] c, input logic m, input logic ci);
        logic [8:0] r;
        r = '0;
        if (m) begin
            case (c)
                4'd0:  r = 9'(int'(a) + int'(b));
                4'd1:  r = 9'(int'(a) - int'(b));
                4'd2:  r = 9'(int'(a) + int'(b) + int'(ci));
                4'd3:  r = 9'(int'(a) - int'(b) - int'(ci));
                4'd4:  r = 9'(int'(a) + 1);
                4'd5:  r = 9'(int'(a) - 1);
                4'd6:  r = 9'(int'(b) + 1);
                4'd7:  r = 9'(int'(b) - 1);
                4'd9:  r = 9'((int'(a) + 1) * (int'(b) + 1));
                4'd10: r = 9'((int'(a) * 2) * int'(b));
                default: r = '0;
            endcase
        end else begin
            case (c)
                4'd0:  r = {1'b0, a & b};
                4'd1:  r = {1'b0, ~(a & b)};
                4'd2:  r = {1'b0, a | b};
                4'd3:  r = {1'b0, ~(a | b)};
                4'd4:  r = {1'b0, a ^ b};
                4'd5:  r = {1'b0, ~(a ^ b)};
                4'd6:  r = {1'b0, ~a};
                4'd7:  r = {1'b0, ~b};
                4'd8:  r = 9'(int'(a) / 2);
                4'd9:  r = 9'(int'(a) * 2);
                4'd10: r = 9'(int'(b) / 2);
                4'd11: r = 9'(int'(b) * 2);
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic logic [1:0] iv_f(input logic [3:0] c, input logic m);
        if (m && (c inside {4'd4, 4'd5}))                return 2'b01;
        if (!m && (c inside {4'd6, 4'd8, 4'd9}))         return 2'b01;
        if (m && (c inside {4'd6, 4'd7}))                return 2'b10;
        if (!m && (c inside {4'd7, 4'd10, 4'd11}))       return 2'b10;
        return 2'b11;
    endfunction

    function automatic int lat_f(input logic [3:0] c, input logic m);
        return (m && (c inside {4'd9, 4'd10})) ? 3 : 1;
    endfunction

    // Behavioural ALU: result registered from whatever is on the bus while ce is high.
    always @(posedge clk) begin
        if (alu_ce)
            alu_res <= alu_f(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] c, input logic m, input logic ci);
        f_opa[r] = a; f_opb[r] = b; f_cmd[r] = c; f_mode[r] = m; f_cin[r] = ci;
        if (r == 0) begin
            req0_opa = a; req0_opb = b; req0_cmd = c; req0_mode = m; req0_cin = ci; req0_valid = 1'b1;
        end else begin
            req1_opa = a; req1_opb = b; req1_cmd = c; req1_mode = m; req1_cin = ci; req1_valid = 1'b1;
        end
    endtask

    task automatic set_rand(input int r);
        set_req(r, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // One full transaction from grant to response handshake; called just after a falling edge.
    task automatic serve(input bit use_tab, input logic [1:0] t_iv, input int t_lat,
                         input logic [8:0] t_res, input int bp, output int wait_n, output int w);
        int n, cyc, ce_n, w_exp, e_lat;
        logic [1:0] e_iv;
        logic [8:0] e_res;
        rsp_ready = 1'b0;
        #1;
        n = 0;
        while (!(req0_ready || req1_ready) && n < 30) begin
            @(negedge clk); #1; n++;
        end
        wait_n = n;
        w_exp = (req0_valid && req1_valid) ? m_prio : (req1_valid ? 1 : 0);
        chk("grant_seen", 32'(req0_ready | req1_ready), 1);
        chk("grant_onehot", 32'(req0_ready & req1_ready), 0);
        w = req1_ready ? 1 : 0;
        chk("grant_id", w, w_exp);
        m_prio = 1 - w_exp;
        if (use_tab) begin
            e_iv = t_iv; e_lat = t_lat; e_res = t_res;
        end else begin
            e_iv  = iv_f(f_cmd[w_exp], f_mode[w_exp]);
            e_lat = lat_f(f_cmd[w_exp], f_mode[w_exp]);
            e_res = alu_f(f_opa[w_exp], f_opb[w_exp], f_cmd[w_exp], f_mode[w_exp], f_cin[w_exp]);
        end
        @(negedge clk);
        if (w == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
        #1;
        chk("issue_ce", alu_ce, 1);
        chk("issue_inp_valid", alu_inp_valid, e_iv);
        chk("issue_opa", alu_opa, f_opa[w_exp]);
        chk("issue_opb", alu_opb, f_opb[w_exp]);
        chk("issue_cmd", alu_cmd, f_cmd[w_exp]);
        chk("issue_busy", busy, 1);
        cyc = 0; ce_n = 0;
        while (!rsp_valid && cyc < 30) begin
            if (alu_ce) ce_n++;
            @(negedge clk); #1; cyc++;
        end
        chk("rsp_latency", cyc, e_lat + 1);
        chk("ce_cycles", ce_n, e_lat + 1);
        chk("rsp_res", rsp_res, e_res);
        chk("rsp_id", rsp_id, w_exp);
        chk("resp_ce", alu_ce, 0);
        chk("resp_inp_valid", alu_inp_valid, 0);
        for (int i = 0; i < bp; i++) begin
            @(negedge clk); #1;
            chk("bp_valid", rsp_valid, 1);
            chk("bp_res", rsp_res, e_res);
            chk("bp_id", rsp_id, w_exp);
            chk("bp_ready", {req0_ready, req1_ready}, 0);
            chk("bp_ce", alu_ce, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_busy", busy, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_res"}, rsp_res, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_alu_ce"}, alu_ce, 0);
        chk({tag, "_alu_iv"}, alu_inp_valid, 0);
        chk({tag, "_alu_ops"}, {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}, 0);
        chk({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    endtask

    initial begin
        vec_t tab[11];
        int   n, w, rem0, rem1, seen;

        tab[0]  = '{0, 8'h0F, 8'h01, 4'd0,  1'b1, 1'b0, 2'b11, 1, 9'h010, 0};
        tab[1]  = '{1, 8'h03, 8'h04, 4'd9,  1'b1, 1'b0, 2'b11, 3, 9'h014, 1};
        tab[2]  = '{0, 8'hFF, 8'h00, 4'd4,  1'b1, 1'b0, 2'b01, 1, 9'h100, 2};
        tab[3]  = '{0, 8'h5A, 8'h3C, 4'd7,  1'b0, 1'b0, 2'b10, 1, 9'h0C3, 0};
        tab[4]  = '{1, 8'h03, 8'h05, 4'd10, 1'b1, 1'b0, 2'b11, 3, 9'h01E, 5};
        tab[5]  = '{1, 8'h81, 8'h00, 4'd8,  1'b0, 1'b0, 2'b01, 1, 9'h040, 0};
        tab[6]  = '{0, 8'h00, 8'h07, 4'd6,  1'b1, 1'b0, 2'b10, 1, 9'h008, 1};
        tab[7]  = '{0, 8'h12, 8'h34, 4'd15, 1'b1, 1'b0, 2'b11, 1, 9'h000, 0};
        tab[8]  = '{1, 8'h05, 8'h03, 4'd9,  1'b0, 1'b0, 2'b01, 1, 9'h00A, 2};
        tab[9]  = '{0, 8'hF0, 8'h0F, 4'd11, 1'b0, 1'b0, 2'b10, 1, 9'h01E, 0};
        tab[10] = '{1, 8'h80, 8'h80, 4'd2,  1'b1, 1'b1, 2'b11, 1, 9'h101, 3};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        m_prio = 0;
        @(negedge clk);

        // Arbitration: both requesters keep four ops queued each
        set_rand(0); set_rand(1);
        rem0 = 3; rem1 = 3;
        for (int i = 0; i < 8; i++) begin
            serve(1'b0, 2'b00, 0, 9'h000, 0, n, w);
            chk("arb_order", w, i % 2);
            if (i > 0) chk("arb_next_cycle_grant", n, 0);
            if (w == 0 && rem0 > 0) begin rem0--; set_rand(0); end
            if (w == 1 && rem1 > 0) begin rem1--; set_rand(1); end
        end

        // Reset in the middle of a multiply; req0 was granted last, so the pointer must return to req0
        set_req(0, 8'h03, 8'h04, 4'd9, 1'b1, 1'b0);
        #1;
        chk("mul_pre_grant", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk_reset_outputs("midrst");
        rst = 1'b1;
        m_prio = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk); #1;
            if (rsp_valid) seen++;
        end
        chk("midrst_no_rsp", seen, 0);
        set_rand(0); set_rand(1);
        serve(1'b0, 2'b00, 0, 9'h000, 0, n, w);
        chk("midrst_ptr_req0", w, 0);
        serve(1'b0, 2'b00, 0, 9'h000, 1, n, w);
        chk("midrst_then_req1", w, 1);

        // Table vectors, one requester at a time
        for (int i = 0; i < 11; i++) begin
            set_req(tab[i].id, tab[i].opa, tab[i].opb, tab[i].cmd, tab[i].mode, tab[i].cin);
            serve(1'b1, tab[i].iv, tab[i].lat, tab[i].res, tab[i].bp, n, w);
        end

        // Backpressure with the other requester waiting, then immediate regrant
        set_req(0, 8'h0F, 8'h01, 4'd0, 1'b1, 1'b0);
        set_rand(1);
        serve(1'b0, 2'b00, 0, 9'h000, 5, n, w);
        serve(1'b0, 2'b00, 0, 9'h000, 0, n, w);
        chk("bp_regrant_next_cycle", n, 0);

        // Randomized traffic against the reference model
        for (int k = 0; k < 40; k++) begin
            if (!req0_valid && $urandom_range(0, 1) == 1) set_rand(0);
            if (!req1_valid && $urandom_range(0, 1) == 1) set_rand(1);
            if (!req0_valid && !req1_valid) set_rand(int'($urandom_range(0, 1)));
            serve(1'b0, 2'b00, 0, 9'h000, int'($urandom_range(0, 3)), n, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
